// File: rtl/aer_pkg.sv
// Constants shared by both ends of the AER spike link: event type codes,
// the default "no spike" time and the receiver state encoding.
package aer_pkg;

  localparam logic        AER_TYPE_DATA = 1'b0;
  localparam logic        AER_TYPE_EOF  = 1'b1;
  localparam logic [31:0] T_MAX_DEFAULT = 32'h7FFF_FFFF;

  // The raw encodings are also used by the transmitter bridge's frame tracking.
  localparam logic [1:0] ST_CLEAR      = 2'd0;
  localparam logic [1:0] ST_RECV       = 2'd1;
  localparam logic [1:0] ST_STREAM     = 2'd2;
  localparam logic [1:0] ST_DONE_PULSE = 2'd3;

  typedef enum logic [1:0] {
    S_CLEAR      = ST_CLEAR,
    S_RECV       = ST_RECV,
    S_STREAM     = ST_STREAM,
    S_DONE_PULSE = ST_DONE_PULSE
  } rx_state_t;

endpackage

// File: rtl/aer_time_store.sv
// Per-address spike-time storage with a seen bit per address. It provides a
// clear sweep, a keep-the-earliest write, and a combinational read.
module aer_time_store
  import aer_pkg::*;
#(
  parameter int              NUM_OUTPUTS = 64,
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = $clog2(NUM_OUTPUTS),
  parameter logic [DATA_W-1:0] T_MAX     = DATA_W'(T_MAX_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_seen,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0]      time_ram [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] seen;
  logic                   new_earlier;

  assign wr_seen     = seen[wr_addr];
  assign rd_data     = time_ram[rd_addr];
  assign new_earlier = $signed(wr_data) < $signed(time_ram[wr_addr]);

  always_ff @(posedge clk) begin
    if (rst) begin
      seen <= '0;
    end else if (en) begin
      if (clr_en)
        seen <= '0;
      else if (wr_en)
        seen[wr_addr] <= 1'b1;
    end
  end

  // The RAM needs no reset: every frame starts with a full clear sweep.
  always_ff @(posedge clk) begin
    if (!rst && en) begin
      if (clr_en)
        time_ram[clr_addr] <= T_MAX;
      else if (wr_en && (!seen[wr_addr] || new_earlier))
        time_ram[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/aer_spike_receiver.sv
// AER receiver. It collects data events into a dense spike-time vector, then
// streams that vector out in address order after the end-of-frame terminator.
module aer_spike_receiver
  import aer_pkg::*;
#(
  parameter int                NUM_OUTPUTS = 64,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] T_MAX       = DATA_W'(T_MAX_DEFAULT),
  parameter int                ADDR_W      = $clog2(NUM_OUTPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clk_enable,
  input  logic              i_req,
  output logic              o_ack,
  input  logic              i_req_type,
  input  logic [DATA_W-1:0] i_spike_time,
  input  logic [ADDR_W-1:0] i_spike_addr,
  output logic              o_result_valid,
  output logic [DATA_W-1:0] o_result_data,
  output logic              o_last_result,
  input  logic              i_result_ack,
  output logic [ADDR_W:0]   o_spike_count,
  output logic              o_err,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_OUTPUTS - 1);

  rx_state_t         state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   spike_count;
  logic              err;
  logic              xfer, is_data, in_range, wr_en, wr_seen;
  logic [DATA_W-1:0] rd_data;

  assign xfer     = i_clk_enable && i_req && (state == S_RECV);
  assign is_data  = (i_req_type == AER_TYPE_DATA);
  assign in_range = ({1'b0, i_spike_addr} < (ADDR_W+1)'(NUM_OUTPUTS));
  assign wr_en    = xfer && is_data && in_range;

  // idx doubles as the clear sweep pointer and the stream read pointer.
  aer_time_store #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .T_MAX       (T_MAX)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .en       (i_clk_enable),
    .clr_en   (state == S_CLEAR),
    .clr_addr (idx),
    .wr_en    (wr_en),
    .wr_addr  (i_spike_addr),
    .wr_data  (i_spike_time),
    .wr_seen  (wr_seen),
    .rd_addr  (idx),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CLEAR;
      idx         <= '0;
      spike_count <= '0;
      err         <= 1'b0;
    end else if (i_clk_enable) begin
      case (state)
        S_CLEAR: begin
          if (idx == IDX_LAST) begin
            state <= S_RECV;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_RECV: begin
          if (i_req) begin
            if (!is_data) begin
              state <= S_STREAM;
              idx   <= '0;
            end else if (!in_range || wr_seen) begin
              err <= 1'b1;
            end else begin
              spike_count <= spike_count + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (i_result_ack) begin
            if (idx == IDX_LAST) begin
              state <= S_DONE_PULSE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_DONE_PULSE: begin
          state       <= S_CLEAR;
          idx         <= '0;
          spike_count <= '0;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  assign o_ack          = (state == S_RECV);
  assign o_result_valid = (state == S_STREAM);
  assign o_result_data  = o_result_valid ? rd_data : '0;
  assign o_last_result  = o_result_valid && (idx == IDX_LAST);
  assign o_done         = (state == S_DONE_PULSE);
  assign o_spike_count  = spike_count;
  assign o_err          = err;

endmodule

// File: tb/tb_aer_spike_receiver.sv
// Randomized bench for aer_spike_receiver with NUM_OUTPUTS=8, checked against
// an address-indexed earliest-time model.
module tb_aer_spike_receiver;
  import aer_pkg::*;

  localparam int          N    = 8;
  localparam int          DW   = 32;
  localparam int          AW   = 3;
  localparam logic [31:0] TMAX = 32'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst, en, req, req_type, res_ack;
  logic [DW-1:0] spike_time;
  logic [AW-1:0] spike_addr;
  logic          ack, res_valid, res_last, err, done;
  logic [DW-1:0] res_data;
  logic [AW:0]   spike_count;

  aer_spike_receiver #(.NUM_OUTPUTS(N), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_clk_enable   (en),
    .i_req          (req),
    .o_ack          (ack),
    .i_req_type     (req_type),
    .i_spike_time   (spike_time),
    .i_spike_addr   (spike_addr),
    .o_result_valid (res_valid),
    .o_result_data  (res_data),
    .o_last_result  (res_last),
    .i_result_ack   (res_ack),
    .o_spike_count  (spike_count),
    .o_err          (err),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_time [N];
  bit m_seen [N];
  int m_count;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_time[i] = int'(TMAX);
      m_seen[i] = 1'b0;
    end
    m_count = 0;
  endtask

  task automatic model_event(input int addr, input int t);
    if (!m_seen[addr]) begin
      m_seen[addr] = 1'b1;
      m_time[addr] = t;
      m_count++;
    end else begin
      if (t < m_time[addr]) m_time[addr] = t;
      m_err = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; res_ack = 1'b0; en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", done, 1'b0);
    end
    rst = 1'b0;
    m_err = 1'b0;
    chk("rst_ack", ack, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_last", res_last, 1'b0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_count", spike_count, 32'd0);
    chk("rst_err", err, 1'b0);
  endtask

  // Leaves the bench on the first S_RECV negedge; req is left as the caller set it.
  task automatic wait_recv(input bit check_len);
    int c = 0;
    en = 1'b1;
    while (!ack && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk("recv_reached", ack, 1'b1);
    if (check_len) chk("clear_len", c, 8);
    model_clear();
  endtask

  task automatic send(input bit typ, input int addr, input int t, input bit rand_en);
    int c = 0;
    req = 1'b1; req_type = typ; spike_addr = AW'(addr); spike_time = t;
    forever begin
      en = rand_en ? ($urandom_range(3) != 0) : 1'b1;
      if (ack && en) break;
      @(negedge clk);
      c++;
      if (c > 200) begin
        chk("send_timeout", c, 0);
        break;
      end
    end
    @(negedge clk);
    req = 1'b0; en = 1'b1;
    if (typ == AER_TYPE_DATA && c <= 200) model_event(addr, t);
  endtask

  task automatic stream(input int stall_word, input int stall_len, input bit rand_stall,
                        input bit rand_en, input int abort_word, input bit hold_req);
    int w = 0;
    int c = 0;
    int st = 0;
    if (hold_req) begin
      req = 1'b1; req_type = AER_TYPE_DATA; spike_addr = 3'd5; spike_time = 33;
    end
    while (w < N && c < 2000) begin
      c++;
      chk("valid", res_valid, 1'b1);
      chk($sformatf("word%0d", w), res_data, m_time[w]);
      chk("last", res_last, w == N - 1);
      if (hold_req) chk("ack_in_stream", ack, 1'b0);
      if (w == abort_word) return;
      en = rand_en ? ($urandom_range(3) != 0) : 1'b1;
      if (w == stall_word && st < stall_len) begin
        res_ack = 1'b0;
        en = st[0];
        st++;
      end else begin
        res_ack = rand_stall ? 1'($urandom_range(1)) : 1'b1;
      end
      if (res_ack && en) w++;
      @(negedge clk);
    end
    res_ack = 1'b0; en = 1'b1;
    chk("stream_complete", w, N);
    chk("done", done, 1'b1);
    chk("valid_after", res_valid, 1'b0);
    chk("count", spike_count, m_count);
    chk("err", err, m_err);
    @(negedge clk);
    chk("done_once", done, 1'b0);
  endtask

  function automatic int rand_time();
    if ($urandom_range(1) != 0) return int'($urandom);
    return int'($urandom_range(40)) - 20;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; req = 1'b0; req_type = 1'b0; res_ack = 1'b0;
    spike_time = '0; spike_addr = '0;
    m_err = 1'b0;
    model_clear();

    // basic frame
    do_reset();
    wait_recv(1'b1);
    send(AER_TYPE_DATA, 3, 10, 1'b0);
    send(AER_TYPE_DATA, 0, 5, 1'b0);
    send(AER_TYPE_EOF, 0, 0, 1'b0);
    chk("basic_w0", m_time[0], 5);
    stream(-1, 0, 1'b0, 1'b0, -1, 1'b0);

    // duplicates keep the earliest time and raise the sticky error
    wait_recv(1'b1);
    send(AER_TYPE_DATA, 2, 20, 1'b0);
    send(AER_TYPE_DATA, 2, 7, 1'b0);
    send(AER_TYPE_DATA, 2, 15, 1'b0);
    send(AER_TYPE_EOF, 0, 0, 1'b0);
    stream(-1, 0, 1'b0, 1'b0, -1, 1'b0);

    // empty frame
    do_reset();
    wait_recv(1'b1);
    send(AER_TYPE_EOF, 0, 0, 1'b0);
    stream(-1, 0, 1'b0, 1'b0, -1, 1'b0);

    // back-pressure on word 4 while enable toggles
    wait_recv(1'b1);
    for (int i = 0; i < 5; i++) send(AER_TYPE_DATA, $urandom_range(N-1), rand_time(), 1'b1);
    send(AER_TYPE_EOF, 0, 0, 1'b1);
    stream(4, 5, 1'b0, 1'b1, -1, 1'b0);

    // reset during the stream abandons the frame
    wait_recv(1'b1);
    for (int i = 0; i < 4; i++) send(AER_TYPE_DATA, $urandom_range(N-1), rand_time(), 1'b0);
    send(AER_TYPE_EOF, 0, 0, 1'b0);
    stream(-1, 0, 1'b0, 1'b0, 3, 1'b0);
    do_reset();
    wait_recv(1'b1);
    send(AER_TYPE_DATA, 1, -4, 1'b0);
    send(AER_TYPE_EOF, 0, 0, 1'b0);
    stream(-1, 0, 1'b0, 1'b0, -1, 1'b0);

    // a request held through stream and clear lands in the first receive cycle
    wait_recv(1'b1);
    send(AER_TYPE_DATA, 6, 100, 1'b0);
    send(AER_TYPE_EOF, 0, 0, 1'b0);
    stream(-1, 0, 1'b0, 1'b0, -1, 1'b1);
    wait_recv(1'b1);
    @(negedge clk);
    req = 1'b0;
    model_event(5, 33);
    chk("gate_count", spike_count, 32'd1);
    send(AER_TYPE_EOF, 0, 0, 1'b0);
    stream(-1, 0, 1'b0, 1'b0, -1, 1'b0);

    // random frames
    for (int f = 0; f < 6; f++) begin
      int k;
      wait_recv(1'b1);
      k = $urandom_range(12);
      for (int i = 0; i < k; i++) send(AER_TYPE_DATA, $urandom_range(N-1), rand_time(), 1'b1);
      send(AER_TYPE_EOF, $urandom_range(N-1), rand_time(), 1'b1);
      stream(-1, 0, 1'b1, 1'b1, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aer_spike_receiver.md
Name: aer_spike_receiver

Overview:
- Receiving end of the AER spike link. Accepts data events and the end-of-frame terminator from an AER transmitter.
- Rebuilds a dense per-address spike-time vector. Addresses that received no event read as T_MAX.
- Streams the vector out in address order on a valid/ack/last result interface to the next layer.
- Pulses o_done once per frame.

Parameters:
- NUM_OUTPUTS, 64, number of addresses and vector length.
- DATA_W, 32, spike-time width in bits, signed.
- T_MAX, 32'h7FFFFFFF, "no spike" value, signed DATA_W bits.
- ADDR_W, $clog2(NUM_OUTPUTS), address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_clk_enable  in  1  global enable; when low, all state is frozen.
- i_req  in  1  event request from the transmitter.
- o_ack  out  1  event accept; a transfer occurs when i_req && o_ack && i_clk_enable.
- i_req_type  in  1  0 = data event, 1 = end-of-frame terminator.
- i_spike_time  in  DATA_W  signed spike time; ignored for terminators.
- i_spike_addr  in  ADDR_W  spike address; ignored for terminators.
- o_result_valid  out  1  stream word valid.
- o_result_data  out  DATA_W  signed spike time for the current stream address.
- o_last_result  out  1  high with the word for address NUM_OUTPUTS-1.
- i_result_ack  in  1  consumer accepts the current word.
- o_spike_count  out  ADDR_W+1  data events accepted in the current or last frame.
- o_err  out  1  sticky error flag: duplicate address or address out of range.
- o_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Interface rule: already decided — one clock; reset is synchronous and active-high (ports clk, rst).
- Qualification: every register update and every transfer also requires i_clk_enable=1.
- Storage: register array time_ram[NUM_OUTPUTS] of DATA_W bits, plus a seen[NUM_OUTPUTS] bit vector.
- State machine: S_CLEAR, S_RECV, S_STREAM, S_DONE_PULSE.
- Reset:
  - State goes to S_CLEAR, the clear counter goes to 0, o_spike_count to 0, o_err to 0.
  - o_ack, o_result_valid, o_last_result, o_done are 0; o_result_data is 0.
  - Reset taken mid-frame abandons the frame; no o_done is produced.
- S_CLEAR:
  - Writes T_MAX to time_ram[cnt] each enabled cycle and clears all seen bits.
  - Lasts exactly NUM_OUTPUTS enabled cycles, then goes to S_RECV.
  - o_ack is 0 throughout; o_spike_count resets to 0 on entry.
- S_RECV:
  - o_ack=1, combinational from state.
  - Data transfer, address < NUM_OUTPUTS, seen[addr]=0: write time, set seen, increment o_spike_count.
  - Data transfer, seen[addr]=1: store min(stored, new), signed compare; set o_err; count is not incremented.
  - Data transfer, address >= NUM_OUTPUTS (non-power-of-2 case): event is dropped; set o_err.
  - Terminator transfer: go to S_STREAM, stream index=0. A terminator with no prior data is legal and streams all T_MAX.
- S_STREAM:
  - o_result_valid=1; o_result_data=time_ram[idx], read combinationally.
  - o_last_result = (idx == NUM_OUTPUTS-1). o_ack=0, so no events are accepted.
  - On i_result_ack, idx increments. On ack of the last word, go to S_DONE_PULSE.
  - Data must hold stable while unacked. Zero-latency ack is allowed, giving 1 word per cycle.
- S_DONE_PULSE: o_done=1 for one cycle; next state S_CLEAR.
- o_err stays set until rst. o_spike_count holds its value through S_STREAM and S_DONE_PULSE.
- Latency:
  - Terminator accepted at cycle t gives first valid word at t+1.
  - Frame-to-frame turnaround is NUM_OUTPUTS+1 cycles (DONE plus CLEAR) when the consumer never stalls.
- Enable low: o_ack and o_result_valid stay at their state-derived values. No transfer occurs, because transfers are qualified by i_clk_enable.

Decomposition:
- Shared package aer_pkg:
  - AER_TYPE_DATA=1'b0, AER_TYPE_EOF=1'b1.
  - Default T_MAX.
  - State encoding localparams shared with the transmitter bridge.
- One natural sub-module: aer_time_store.
  - Holds time_ram and seen, with a clear-sweep port, a min-write port and a combinational read port.
  - The receiver FSM instantiates it.

Test Plan:
- Basic frame:
  - Stimulus (NUM_OUTPUTS=8): after clear, send events addr3=10, addr0=5, then EOF.
  - Required response: stream 5,T_MAX,T_MAX,10,T_MAX×4; last on word 8; o_spike_count=2; o_done one cycle after word 8 is acked.
- Duplicate:
  - Stimulus: addr2=20, addr2=7, addr2=15, then EOF.
  - Required response: word2=7; o_err=1; o_spike_count=1.
- Empty frame:
  - Stimulus: EOF immediately after clear.
  - Required response: 8×T_MAX; o_spike_count=0; o_err=0.
- Back-pressure:
  - Stimulus: hold i_result_ack=0 for 5 cycles on word 4, also toggle i_clk_enable.
  - Required response: data and valid stable; no skipped or repeated words.
- Reset mid-stream:
  - Stimulus: assert rst at word 3, then run a new frame with addr1=-4.
  - Required response: no o_done for the aborted frame; o_ack=0 for 8 cycles of clear; new stream word1=-4, others T_MAX.
- Gating:
  - Stimulus: hold i_req=1 during S_CLEAR and S_STREAM.
  - Required response: o_ack=0 in both states; the event is accepted in the first S_RECV cycle.
